lsu_mem_port: RTL and testbench

- Load/store unit between the single-cycle RV32I core and a word-addressed data memory with ready/ack handshake.
- Stores: drives byte-lane strobes and lane-replicated write data.
- Loads: selects and sign/zero-extends the addressed byte/half/word. The result is the mem_data input of the writeback mux.
- Stalls the core (PC hold) while the memory transaction is outstanding.

---
 rtl/lsu_mem_port.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the single-cycle RV32I core and a
// word-addressed data memory with a req/ack handshake.
// Stores drive byte-lane strobes and lane-replicated write data; loads pick
// and extend the addressed byte/half/word.  The core is stalled while a
// memory transaction is outstanding.
// Optional feature: define LSU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without an ack (access_err pulse, mem_data=0).
module lsu_mem_port #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   output logic [31:0]       mem_data,
   output logic              stall,
   output logic              access_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_mem_data;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic              r_to_err;

   logic              w_idle;
   logic              w_op;
   logic              w_illegal_f3;
   logic              w_misaligned;
   logic              w_err;
   logic              w_start;
   logic              w_timeout;
   logic [3:0]        w_st_be;
   logic [31:0]       w_st_wdata;
   logic [31:0]       w_load_val;

   // Request decode: classify the op presented in IDLE as start, error or none.
   always_comb begin
      w_idle       = (r_state == S_IDLE);
      w_op         = MemRead | MemWrite;
      w_illegal_f3 = (MemRead  && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) ||
                     (MemWrite && (funct3[2] || funct3 == 3'b011));
      w_misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
      w_err        = w_idle && w_op &&
                     ((MemRead && MemWrite) || w_illegal_f3 || w_misaligned);
      w_start      = w_idle && w_op && !w_err;
   end

   // Store lane steering: strobe shifted to the byte offset, data replicated to every lane.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_st_be    = 4'b1111;
      w_st_wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            w_st_be    = 4'b0001 << addr[1:0];
            w_st_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            w_st_be    = 4'b0011 << addr[1:0];
            w_st_wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the returned word, using the size and offset latched at request time.
   always_comb begin
      logic [7:0]  v_byte;
      logic [15:0] v_half;
      v_byte     = mem_rdata[8*r_off +: 8];
      v_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_load_val = mem_rdata;
      case (r_funct3)
         3'b000:  w_load_val = {{24{v_byte[7]}}, v_byte};
         3'b100:  w_load_val = {24'd0, v_byte};
         3'b001:  w_load_val = {{16{v_half[15]}}, v_half};
         3'b101:  w_load_val = {16'd0, v_half};
         default: w_load_val = mem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_wait_cnt;

   // Wait counter: zero outside WAIT, counts WAIT cycles that pass without an ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state != S_WAIT) begin
         r_wait_cnt <= '0;
      end else if (!mem_ack) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == S_WAIT) && !mem_ack &&
                      (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Transaction FSM with registered memory-side outputs and load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= '0;
         r_mem_data  <= '0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         r_to_err    <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         r_to_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state     <= S_WAIT;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= MemWrite;
                  r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_mem_be    <= MemWrite ? w_st_be : 4'b1111;
                  r_mem_wdata <= MemWrite ? w_st_wdata : 32'd0;
                  r_funct3    <= funct3;
                  r_off       <= addr[1:0];
               end else if (w_err) begin
                  r_mem_data  <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (!r_mem_we) r_mem_data <= w_load_val;
                  r_state   <= S_DONE;
               end else if (w_timeout) begin
                  r_mem_req  <= 1'b0;
                  r_mem_data <= '0;
                  r_to_err   <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            // DONE always returns to IDLE; a still-asserted op is not re-issued here.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall      = w_start || (r_state == S_WAIT);
   assign access_err = w_err || r_to_err;
   assign mem_data   = w_err ? 32'd0 : r_mem_data;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases followed by random
// transactions, all compared against a behavioural model of the LSU rules.
module tb_lsu_mem_port;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [31:0] mem_data;
   logic        stall, access_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_md      = 32'd0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .mem_data(mem_data), .stall(stall), .access_err(access_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---- reference model ----
   function automatic bit model_err(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a);
      bit legal;
      if (rd && wr) return 1'b1;
      if (rd) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
      if (!legal) return 1'b1;
      if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
      if (f3 == 2 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) & 32'hFF;
      h = (w >> (8 * (a % 4))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      if (!wr || f3 == 2) return 32'hF;
      if (f3 == 0) return 32'd1 << (a % 4);
      return 32'd3 << (a % 4);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3 == 0) return (sd & 32'hFF) * 32'h01010101;
      if (f3 == 1) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   // One complete core access: ack arrives in WAIT cycle number lat (0 = first).
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int lat);
      bit          err;
      int          stall_cnt;
      logic [31:0] ea, ebe, ewd;
      MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (!rd && !wr) begin
         check("noop_stall", stall, 0);
         check("noop_err", access_err, 0);
         tick();
         check("noop_req", mem_req, 0);
         return;
      end
      err = model_err(rd, wr, f3, a);
      check("idle_access_err", access_err, err);
      check("idle_stall", stall, !err);
      if (err) begin
         exp_md = 32'd0;
         check("err_mem_data", mem_data, 32'd0);
         tick();
         MemRead = 1'b0; MemWrite = 1'b0;
         #1;
         check("err_no_req", mem_req, 0);
         check("err_pulse_end", access_err, 0);
         check("err_mem_data_after", mem_data, exp_md);
         return;
      end
      ea  = a & 32'hFFFF_FFFC;
      ebe = model_be(wr, f3, a);
      ewd = model_wdata(f3, sd);
      stall_cnt = 1;
      tick();
      for (int k = 0; k <= lat; k++) begin
         mem_ack   = (k == lat);
         mem_rdata = (k == lat) ? rdata : $urandom;
         #1;
         if (stall) stall_cnt++;
         check("wait_req", mem_req, 1);
         check("wait_we", mem_we, wr);
         check("wait_addr", mem_addr, ea);
         check("wait_be", mem_be, ebe);
         if (wr) check("wait_wdata", mem_wdata, ewd);
         tick();
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      #1;
      if (rd) exp_md = model_load(f3, a, rdata);
      check("stall_cycles", stall_cnt, lat + 2);
      check("done_stall", stall, 0);
      check("done_req", mem_req, 0);
      check("done_mem_data", mem_data, exp_md);
      check("done_err", access_err, 0);
      tick();
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      check("no_restart_req", mem_req, 0);
      check("no_restart_stall", stall, 0);
   endtask

   initial begin
      rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
      addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
      tick(); tick();
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_be", mem_be, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_stall", stall, 0);
      check("rst_err", access_err, 0);
      rst = 1'b0;

      // ack while IDLE is ignored
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      check("idle_ack_req", mem_req, 0);
      check("idle_ack_data", mem_data, 0);

      // directed loads and stores
      run_op(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
      run_op(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 1);
      run_op(1, 0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 0);
      run_op(1, 0, 3'b001, 32'h102, 32'd0, 32'h80FF_0000, 0);
      run_op(1, 0, 3'b101, 32'h102, 32'd0, 32'h80FF_0000, 2);
      run_op(0, 1, 3'b000, 32'h201, 32'h0000_00AB, 32'd0, 0);
      run_op(0, 1, 3'b001, 32'h202, 32'h0000_1234, 32'd0, 2);
      run_op(0, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'd0, 1);

      // error cases
      run_op(1, 0, 3'b010, 32'h102, 32'd0, 32'd0, 0);
      run_op(1, 0, 3'b011, 32'h100, 32'd0, 32'd0, 0);
      run_op(1, 0, 3'b001, 32'h101, 32'd0, 32'd0, 0);
      run_op(0, 1, 3'b100, 32'h100, 32'd0, 32'd0, 0);
      run_op(1, 1, 3'b010, 32'h100, 32'd0, 32'd0, 0);

      // ack on fifth WAIT cycle: stall high 6 cycles, outputs stable throughout
      run_op(1, 0, 3'b010, 32'h180, 32'd0, 32'h1357_9BDF, 4);

      // reset during WAIT, then a late ack
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h300;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("rstwait_stall_before", stall, 1);
      check("rstwait_req_before", mem_req, 1);
      tick();
      rst = 1'b0; MemRead = 1'b0;
      #1;
      exp_md = 32'd0;
      check("rstwait_req", mem_req, 0);
      check("rstwait_stall", stall, 0);
      check("rstwait_addr", mem_addr, 0);
      check("rstwait_be", mem_be, 0);
      check("rstwait_data", mem_data, exp_md);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      check("late_ack_req", mem_req, 0);
      check("late_ack_data", mem_data, exp_md);

`ifdef LSU_TIMEOUT_EN
      // no ack: abort after TO WAIT cycles
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h400;
      tick();
      for (int k = 0; k < TO; k++) begin
         check("to_wait_req", mem_req, 1);
         check("to_wait_stall", stall, 1);
         tick();
      end
      exp_md = 32'd0;
      check("to_req", mem_req, 0);
      check("to_err", access_err, 1);
      check("to_data", mem_data, exp_md);
      check("to_stall", stall, 0);
      MemRead = 1'b0;
      tick();
      check("to_err_end", access_err, 0);
`endif

      // randomized transactions
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  rw;
         logic [2:0]  f3;
         logic [31:0] a;
         rw = 2'($urandom_range(0, 3));
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) == 1 && rw == 2'b01) ? 3'b100 : 3'b000);
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & ~32'd3 | ((f3[1:0] == 2'b01) ? (a & 32'd2) : 32'd0);
         run_op(rw[0], rw[1], f3, a, $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
